// File: rtl/execute_muldiv_unit_pkg.sv
// Shared types and constants for the iterative RV64M multiply/divide unit.
// Op encodings follow func3; state and corner-case result constants live here.
package execute_muldiv_unit_pkg;

  localparam int MDU_DATA_WIDTH = 64;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } mdu_state_t;

  // Divide-by-zero quotient, and the signed-overflow (MIN / -1) operands and results.
  localparam logic [MDU_DATA_WIDTH-1:0] DIVZ_QUOT  = {MDU_DATA_WIDTH{1'b1}};
  localparam logic [MDU_DATA_WIDTH-1:0] MINUS_ONE  = {MDU_DATA_WIDTH{1'b1}};
  localparam logic [MDU_DATA_WIDTH-1:0] OVF_QUOT   = {1'b1, {(MDU_DATA_WIDTH-1){1'b0}}};
  localparam logic [MDU_DATA_WIDTH-1:0] OVF_QUOT_W = {{(MDU_DATA_WIDTH/2+1){1'b1}},
                                                      {(MDU_DATA_WIDTH/2-1){1'b0}}};
  localparam logic [MDU_DATA_WIDTH-1:0] OVF_REM    = {MDU_DATA_WIDTH{1'b0}};

endpackage

// File: rtl/execute_muldiv_unit.sv
// Bit-serial RV64M multiply/divide unit: stalls execute while iterating,
// then pulses o_done with the result for the writeback mux.
module execute_muldiv_unit
  import execute_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = MDU_DATA_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  output logic                  o_stall_exec,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int HW = DATA_WIDTH / 2;
  localparam int CW = $clog2(DATA_WIDTH);

  function automatic logic [W-1:0] sext_half(input logic [HW-1:0] v);
    sext_half = {{HW{v[HW-1]}}, v};
  endfunction

  mdu_state_t     state_r;
  mdu_op_t        op_r;
  logic [CW-1:0]  count_r;
  logic           word_r;
  logic           neg_q_r;
  logic           neg_r_r;
  logic [W-1:0]   operand_r;
  logic [2*W-1:0] mul_acc_r;
  logic [W-1:0]   div_quot_r;
  logic [W-1:0]   div_rem_r;
  logic           done_r;
  logic [W-1:0]   result_r;

  logic           a_signed_s, b_signed_s, a_neg_s, b_neg_s;
  logic           is_div_s, div_zero_s, div_ovf_s, fast_s;
  logic [W-1:0]   a_ext_s, b_ext_s, a_mag_s, b_mag_s, fast_raw_s, fast_res_s;

  logic [W:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*W-1:0] mul_acc_nxt_s, mul_prod_s, mul_fix_s;
  logic [W-1:0]   mul_res_s;
  logic [W-1:0]   div_quot_nxt_s, div_rem_nxt_s, div_q_fix_s, div_r_fix_s, div_sel_s, div_res_s;

  // Operand prep: extension, magnitudes, result signs and the single-cycle corner cases.
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (mdu_op_t'(i_func3))
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b0;
      end
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase

    if (i_word) begin
      a_ext_s = a_signed_s ? sext_half(i_rs1_data[HW-1:0]) : {{HW{1'b0}}, i_rs1_data[HW-1:0]};
      b_ext_s = b_signed_s ? sext_half(i_rs2_data[HW-1:0]) : {{HW{1'b0}}, i_rs2_data[HW-1:0]};
    end else begin
      a_ext_s = i_rs1_data;
      b_ext_s = i_rs2_data;
    end

    a_neg_s = a_signed_s & a_ext_s[W-1];
    b_neg_s = b_signed_s & b_ext_s[W-1];
    a_mag_s = a_neg_s ? -a_ext_s : a_ext_s;
    b_mag_s = b_neg_s ? -b_ext_s : b_ext_s;

    is_div_s   = i_func3[2];
    div_zero_s = is_div_s & (b_ext_s == {W{1'b0}});
    div_ovf_s  = is_div_s & ~i_func3[0] & (b_ext_s == MINUS_ONE) &
                 (a_ext_s == (i_word ? OVF_QUOT_W : OVF_QUOT));
    fast_s     = div_zero_s | div_ovf_s;

    // On overflow the dividend already equals the MIN quotient at the op's width.
    if (div_zero_s) begin
      fast_raw_s = i_func3[1] ? a_ext_s : DIVZ_QUOT;
    end else begin
      fast_raw_s = i_func3[1] ? OVF_REM : a_ext_s;
    end
    fast_res_s = i_word ? sext_half(fast_raw_s[HW-1:0]) : fast_raw_s;
  end

  // One shift-add multiply step and its final sign fix / half select.
  always_comb begin
    mul_sum_s     = {1'b0, mul_acc_r[2*W-1:W]} +
                    (mul_acc_r[0] ? {1'b0, operand_r} : {(W+1){1'b0}});
    mul_acc_nxt_s = {mul_sum_s, mul_acc_r[W-1:1]};
    // W-ops run half the iterations, leaving the product HW bits higher.
    mul_prod_s    = word_r ? (mul_acc_nxt_s >> HW) : mul_acc_nxt_s;
    mul_fix_s     = neg_q_r ? -mul_prod_s : mul_prod_s;
    if (word_r) begin
      mul_res_s = sext_half(mul_fix_s[HW-1:0]);
    end else if (op_r == OP_MUL) begin
      mul_res_s = mul_fix_s[W-1:0];
    end else begin
      mul_res_s = mul_fix_s[2*W-1:W];
    end
  end

  // One restoring-division step and its final sign fix / quotient-remainder select.
  always_comb begin
    div_shift_s = {div_rem_r, div_quot_r[W-1]};
    div_diff_s  = div_shift_s - {1'b0, operand_r};
    if (!div_diff_s[W]) begin
      div_rem_nxt_s  = div_diff_s[W-1:0];
      div_quot_nxt_s = {div_quot_r[W-2:0], 1'b1};
    end else begin
      div_rem_nxt_s  = div_shift_s[W-1:0];
      div_quot_nxt_s = {div_quot_r[W-2:0], 1'b0};
    end
    div_q_fix_s = neg_q_r ? -div_quot_nxt_s : div_quot_nxt_s;
    div_r_fix_s = neg_r_r ? -div_rem_nxt_s : div_rem_nxt_s;
    div_sel_s   = op_r[1] ? div_r_fix_s : div_q_fix_s;
    div_res_s   = word_r ? sext_half(div_sel_s[HW-1:0]) : div_sel_s;
  end

  // Control FSM with datapath registers; flush wins over everything but reset.
  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_r    <= IDLE;
      op_r       <= OP_MUL;
      count_r    <= {CW{1'b0}};
      word_r     <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      operand_r  <= {W{1'b0}};
      mul_acc_r  <= {(2*W){1'b0}};
      div_quot_r <= {W{1'b0}};
      div_rem_r  <= {W{1'b0}};
      done_r     <= 1'b0;
      result_r   <= {W{1'b0}};
    end else if (i_flush) begin
      state_r <= IDLE;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (i_start) begin
            op_r    <= mdu_op_t'(i_func3);
            word_r  <= i_word;
            neg_q_r <= a_neg_s ^ b_neg_s;
            neg_r_r <= a_neg_s;
            count_r <= i_word ? CW'(HW - 1) : CW'(W - 1);
            if (is_div_s) begin
              operand_r  <= b_mag_s;
              div_quot_r <= i_word ? (a_mag_s << HW) : a_mag_s;
              div_rem_r  <= {W{1'b0}};
            end else begin
              operand_r <= a_mag_s;
              mul_acc_r <= {{W{1'b0}}, b_mag_s};
            end
            if (fast_s) begin
              state_r  <= DONE;
              done_r   <= 1'b1;
              result_r <= fast_res_s;
            end else if (is_div_s) begin
              state_r <= DIV;
            end else begin
              state_r <= MUL;
            end
          end
        end
        MUL: begin
          mul_acc_r <= mul_acc_nxt_s;
          if (count_r == {CW{1'b0}}) begin
            state_r  <= DONE;
            done_r   <= 1'b1;
            result_r <= mul_res_s;
          end else begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DIV: begin
          div_quot_r <= div_quot_nxt_s;
          div_rem_r  <= div_rem_nxt_s;
          if (count_r == {CW{1'b0}}) begin
            state_r  <= DONE;
            done_r   <= 1'b1;
            result_r <= div_res_s;
          end else begin
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign o_stall_exec = ((state_r == IDLE) & i_start & ~i_flush) |
                        (state_r == MUL) | (state_r == DIV);
  assign o_done       = done_r;
  assign o_result     = result_r;

endmodule

// File: tb/tb_execute_muldiv_unit.sv
// Scoreboard bench for execute_muldiv_unit: expected results queued at issue,
// compared when o_done pulses; stall length and flush/reset corners checked inline.
module tb_execute_muldiv_unit;
  import execute_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        arst, start, flush, word;
  logic [2:0]  func3;
  logic [63:0] rs1, rs2;
  logic        stall, done;
  logic [63:0] result;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_results = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_res = 64'd0;
  logic [63:0] ra, rb;
  logic [127:0] p128;

  always #5 clk = ~clk;

  execute_muldiv_unit #(.DATA_WIDTH(64)) dut (
    .i_clk(clk), .i_arst(arst), .i_start(start), .i_flush(flush),
    .i_func3(func3), .i_word(word), .i_rs1_data(rs1), .i_rs2_data(rs2),
    .o_stall_exec(stall), .o_done(done), .o_result(result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Scoreboard: every o_done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!arst && done) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", 64'(done), 64'd0);
      end else begin
        last_res = exp_q.pop_front();
        check_eq($sformatf("result#%0d", n_results), result, last_res);
        n_results++;
      end
    end
  end

  // Issues one op from idle and returns one step into its DONE cycle.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_stall);
    int stalls = 0;
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(exp);
    func3 = f3; word = w; rs1 = a; rs2 = b; start = 1'b1;
    #1;
    while (stall && stalls < 200) begin
      stalls++;
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    start = 1'b0;
    check_eq({tag, "_stall"}, 64'(stalls), 64'(exp_stall));
    check_eq({tag, "_done"}, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; start = 1'b0; flush = 1'b0; word = 1'b0;
    func3 = 3'd0; rs1 = 64'd0; rs2 = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_stall", 64'(stall), 64'd0);
    arst = 1'b0;

    do_op("mul", 3'd0, 1'b0, 64'd7, -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    @(posedge clk); #1;
    check_eq("mul_pulse", 64'(done), 64'd0);
    do_op("mulhu", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1, 65);
    do_op("mulh", 3'd1, 1'b0, -64'sd1, -64'sd1, 64'd0, 65);
    do_op("mulhsu", 3'd2, 1'b0, -64'sd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("div", 3'd4, 1'b0, -64'sd7, 64'd2, -64'sd3, 65);
    do_op("rem", 3'd6, 1'b0, -64'sd7, 64'd2, -64'sd1, 65);
    do_op("divw_ovf", 3'd4, 1'b1, 64'h0000_0000_8000_0000, -64'sd1, 64'hFFFF_FFFF_8000_0000, 1);
    do_op("div_ovf", 3'd4, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf", 3'd6, 1'b0, 64'h8000_0000_0000_0000, -64'sd1, 64'd0, 1);
    do_op("divu_z", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("remu_z", 3'd7, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    do_op("remw_z", 3'd6, 1'b1, 64'h0000_0001_FFFF_FFFB, 64'hFFFF_FFFF_0000_0000,
          64'hFFFF_FFFF_FFFF_FFFB, 1);
    do_op("remw", 3'd6, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2, -64'sd1, 33);
    do_op("divuw", 3'd5, 1'b1, 64'h1234_5678_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 33);
    do_op("mulw", 3'd0, 1'b1, 64'h0000_0001_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 33);

    ra = 64'hDEAD_BEEF_1234_5678;
    rb = 64'h0000_0000_0012_3457;
    do_op("divu_big", 3'd5, 1'b0, ra, rb, ra / rb, 65);
    do_op("remu_big", 3'd7, 1'b0, ra, rb, ra % rb, 65);
    do_op("mul_big", 3'd0, 1'b0, ra, rb, ra * rb, 65);
    p128 = {64'd0, ra} * {64'd0, rb};
    do_op("mulhu_big", 3'd3, 1'b0, ra, rb, p128[127:64], 65);

    // Flush together with a start in idle: nothing may be accepted.
    @(negedge clk); @(negedge clk);
    func3 = 3'd0; word = 1'b0; rs1 = 64'd9; rs2 = 64'd9; start = 1'b1; flush = 1'b1;
    #1;
    check_eq("flush_start_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check_eq("flush_start_idle", 64'(stall), 64'd0);

    // Flush at iteration 10 of a divide.
    @(negedge clk);
    func3 = 3'd4; word = 1'b0; rs1 = 64'd100; rs2 = 64'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_eq("flush_busy", 64'(stall), 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_stall", 64'(stall), 64'd0);
    check_eq("flush_done", 64'(done), 64'd0);
    check_eq("flush_hold", result, last_res);
    do_op("mulw_after_flush", 3'd0, 1'b1, 64'd3, 64'd4, 64'd12, 33);

    // Reset at iteration 30 of a divide.
    @(negedge clk); @(negedge clk);
    func3 = 3'd4; word = 1'b0; rs1 = 64'd1000; rs2 = 64'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    check_eq("arst_done", 64'(done), 64'd0);
    check_eq("arst_result", result, 64'd0);
    check_eq("arst_stall", 64'(stall), 64'd0);
    last_res = 64'd0;

    // Back-to-back: a start held during DONE is taken one cycle later.
    do_op("divu_b2b", 3'd5, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    exp_q.push_back(64'd5);
    func3 = 3'd7; word = 1'b0; rs1 = 64'd5; rs2 = 64'd0; start = 1'b1;
    #1;
    check_eq("b2b_in_done_stall", 64'(stall), 64'd0);
    @(posedge clk); #1;
    check_eq("b2b_wait_stall", 64'(stall), 64'd1);
    check_eq("b2b_wait_done", 64'(done), 64'd0);
    @(posedge clk); #1;
    start = 1'b0;
    check_eq("b2b_done", 64'(done), 64'd1);

    repeat (3) @(negedge clk);
    check_eq("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
